be_cmd_dispatch: RTL
====================

# be_cmd_dispatch

Parametrised back-end command dispatcher between the UART RX command path and the per-channel UART-FIFO units (UFUs). It accepts one 8-bit command at a time, decodes it into a one-cycle start or flush pulse for one of NUM_CH channels, and waits for that channel's done with a programmable timeout. It then returns a one-byte status response towards the UART TX path. It generalises single-channel, SEND-only command handling: multiple channels, a FLUSH opcode, a timeout, error reporting and ready/valid handshakes on both sides.

## Interface
- NUM_CH, 4, number of UFU channels, 1..16
- TIMEOUT, 50000, max WAIT cycles before abort; 0 disables the timeout
- TIMEOUT_W, 16, timer width; must satisfy TIMEOUT < 2**TIMEOUT_W
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command byte valid
- cmd  in  8  command: [7:4] channel, [3:0] opcode (0x01 = SEND on channel 0)
- cmd_ready  out  1  high only in IDLE
- start  out  NUM_CH  one-hot, one-cycle SEND pulse to a UFU
- flush  out  NUM_CH  one-hot, one-cycle flush pulse to a UFU
- done  in  NUM_CH  per-channel UFU done (pulse or level)
- busy  out  1  high in every state except IDLE
- rsp_valid  out  1  response byte valid
- rsp_data  out  8  [7:4] status, [3:0] channel
- rsp_ready  in  1  response consumer ready

## Operation
- Opcodes: SEND = 0x1, FLUSH = 0x2. Any other opcode, or channel >= NUM_CH, is an error.
- Status codes: OK = 0x0, TIMEOUT = 0x1, ERR = 0xE.
- States: IDLE, WAIT, RESP.
- IDLE: cmd_ready = 1.
  - Valid SEND accepted: latch ch, clear timer, assert start[ch], go to WAIT.
  - Valid FLUSH accepted: assert flush[ch], load rsp_data = {OK, ch}, go to RESP.
  - Error command accepted: no pulses, load rsp_data = {ERR, cmd[7:4]}, go to RESP.
- WAIT:
  - done[ch] high: load {OK, ch}, go to RESP.
  - Otherwise, if TIMEOUT != 0 and timer == TIMEOUT-1: assert flush[ch], load {TIMEOUT, ch}, go to RESP.
  - Otherwise increment timer.
  - done and timeout in the same cycle: done wins, no flush pulse.
  - done on any other channel is ignored.
- RESP: rsp_valid = 1 and rsp_data held stable until rsp_ready; on handshake go to IDLE.
- Reset at any point: state IDLE, timer 0, all outputs 0. Any in-flight command and pending response are discarded, and no pulse is emitted.
- Reset values: cmd_ready 0 while rst is asserted, 1 from the first cycle after release. start, flush, busy, rsp_valid and rsp_data are all 0.

## Timing
- All outputs are registered; start and flush are high for exactly one cycle.
- Command accepted on the edge where cmd_valid && cmd_ready.
  - start[ch] or flush[ch] is high in the following cycle (cycle 1).
  - cmd_ready and busy update in the same cycle.
- done is sampled in every WAIT cycle, including cycle 1. Minimum SEND turnaround: done high in cycle 1 gives rsp_valid in cycle 2.
- FLUSH and error commands: rsp_valid in cycle 1.
- Timeout: done never arrives. The flush pulse and rsp_valid rise together, TIMEOUT cycles after start.
- Next command is accepted no earlier than the cycle after the response handshake. There is no pipelining or overlap between commands.
- A done held high as a level and left asserted across commands is only seen in WAIT; it is not latched in IDLE.

## Structure
- Package be_cmd_pkg holds:
  - opcode constants OP_SEND and OP_FLUSH;
  - status constants ST_OK, ST_TIMEOUT and ST_ERR;
  - the state enum.
- One sub-module, be_cmd_timer: TIMEOUT_W-bit counter with clear, enable and an expire output. It is instantiated once.
- The channel decode is written inline, not as a separate module.

## Test plan
- NUM_CH=4, cmd 0x01, done[0] pulsed 5 cycles after start[0] -> start = 4'b0001 for exactly 1 cycle, then rsp_data 0x00; busy high throughout.
- cmd 0x22 -> flush = 4'b0100 in cycle 1 and rsp_data 0x02 in cycle 1; start never asserts.
- TIMEOUT=8, cmd 0x31, done tied 0 -> flush[3] pulse and rsp 0x13 both exactly 8 cycles after start[3].
- cmd 0x05 (bad opcode), then cmd 0x51 with NUM_CH=4 (bad channel) -> rsp 0xE0 then 0xE5; no start or flush pulses.
- rsp_ready held low for 10 cycles during RESP -> rsp_valid and rsp_data stable, cmd_ready 0, and a second cmd_valid is not accepted until after the handshake.
- rst asserted mid-WAIT, and in a separate run done[1] and timer expiry in the same cycle -> all outputs 0 and return to IDLE; done/expiry case responds 0x01 with no flush pulse.

Source files
------------

// File: rtl/be_cmd_pkg.sv
// be_cmd_pkg: shared definitions for the back-end command dispatcher.
//   - opcode constants (low nibble of a command byte)
//   - status constants (high nibble of a response byte)
//   - dispatcher state encoding
package be_cmd_pkg;

    localparam logic [3:0] OP_SEND  = 4'h1;
    localparam logic [3:0] OP_FLUSH = 4'h2;

    localparam logic [3:0] ST_OK      = 4'h0;
    localparam logic [3:0] ST_TIMEOUT = 4'h1;
    localparam logic [3:0] ST_ERR     = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/be_cmd_timer.sv
// be_cmd_timer: WAIT-phase timeout counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force count to 0 (has priority over enable)
//   enable   : increment count by one
//   expire   : count has reached TIMEOUT-1 (never asserted when TIMEOUT == 0)
module be_cmd_timer #(
    parameter int TIMEOUT   = 50000,
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // For TIMEOUT == 0 this wraps to all ones, but expire is gated off anyway.
    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/be_cmd_dispatch.sv
// be_cmd_dispatch: accepts one command byte at a time, pulses start/flush
// towards one UFU channel, waits for done (with timeout) on SEND, and
// returns a one-byte status response.
//   clk, rst   : clock, asynchronous active-high reset
//   cmd_valid, cmd, cmd_ready : command handshake ([7:4] channel, [3:0] opcode)
//   start, flush : one-hot, one-cycle pulses to the UFUs
//   done       : per-channel completion from the UFUs
//   busy       : high whenever a command is in flight
//   rsp_valid, rsp_data, rsp_ready : response handshake ([7:4] status, [3:0] channel)
//
//   state  | meaning
//   IDLE   | ready for a command
//   WAIT   | SEND issued, waiting for done[ch] or timeout
//   RESP   | response byte presented, waiting for rsp_ready
module be_cmd_dispatch #(
    parameter int NUM_CH    = 4,
    parameter int TIMEOUT   = 50000,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd,
    output logic              cmd_ready,
    output logic [NUM_CH-1:0] start,
    output logic [NUM_CH-1:0] flush,
    input  logic [NUM_CH-1:0] done,
    output logic              busy,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    input  logic              rsp_ready
);

    import be_cmd_pkg::*;

    state_t            state, state_n;
    logic [3:0]        ch_q, ch_n;
    logic [NUM_CH-1:0] start_n, flush_n;
    logic [7:0]        rsp_n;
    logic [NUM_CH-1:0] cmd_dec, ch_dec;
    logic              accept, ch_valid, is_send, is_flush;
    logic              done_hit, expire, tmr_clr, tmr_en;

    // Channel decode; an out-of-range channel decodes to all zeros,
    // which doubles as the channel range check.
    always_comb begin
        cmd_dec = '0;
        ch_dec  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cmd_dec[i] = (cmd[7:4] == 4'(i));
            ch_dec[i]  = (ch_q == 4'(i));
        end
    end

    assign accept   = cmd_valid && cmd_ready;
    assign ch_valid = |cmd_dec;
    assign is_send  = ch_valid && (cmd[3:0] == OP_SEND);
    assign is_flush = ch_valid && (cmd[3:0] == OP_FLUSH);
    assign done_hit = |(done & ch_dec);

    be_cmd_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .expire (expire)
    );

    // State register; all outputs are registered from the next-state values
    // so they change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ch_q      <= '0;
            start     <= '0;
            flush     <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            ch_q      <= ch_n;
            start     <= start_n;
            flush     <= flush_n;
            rsp_data  <= rsp_n;
            rsp_valid <= (state_n == S_RESP);
            busy      <= (state_n != S_IDLE);
            cmd_ready <= (state_n == S_IDLE);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = is_send ? S_WAIT : S_RESP;
            S_WAIT: if (done_hit || expire) state_n = S_RESP;
            S_RESP: if (rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        start_n = '0;
        flush_n = '0;
        rsp_n   = rsp_data;
        ch_n    = ch_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    ch_n = cmd[7:4];
                    if (is_send) begin
                        start_n = cmd_dec;
                        tmr_clr = 1'b1;
                    end else if (is_flush) begin
                        flush_n = cmd_dec;
                        rsp_n   = {ST_OK, cmd[7:4]};
                    end else begin
                        rsp_n   = {ST_ERR, cmd[7:4]};
                    end
                end
            end
            S_WAIT: begin
                // done takes priority over a coincident expiry: no flush then.
                if (done_hit) begin
                    rsp_n = {ST_OK, ch_q};
                end else if (expire) begin
                    flush_n = ch_dec;
                    rsp_n   = {ST_TIMEOUT, ch_q};
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
